// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline stage built as a two-entry skid buffer (head M, skid S)
// with valid/ready handshakes, flush, x0 write suppression, a youngest-entry
// forwarding port and a saturating back-pressure stall counter.
module mem_wb_skid_stage #(
  parameter int DATA_W        = 64,
  parameter int ADDR_W        = 5,
  parameter int CNT_W         = 16,
  parameter bit ZERO_SUPPRESS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rd_addr,
  input  logic              in_wreg,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_rd_addr,
  output logic              out_wreg,
  output logic [DATA_W-1:0] out_wdata,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_rd_addr,
  output logic [DATA_W-1:0] fwd_wdata,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + CNT_W'(1);
  endfunction

  // Head (M) and skid (S) entry registers.
  logic              m_vld_p1, s_vld_p1;
  logic [ADDR_W-1:0] m_rd_p1, s_rd_p1;
  logic              m_wreg_p1, s_wreg_p1;
  logic [DATA_W-1:0] m_data_p1, s_data_p1;

  logic              m_vld_nxt, s_vld_nxt;
  logic [ADDR_W-1:0] m_rd_nxt, s_rd_nxt;
  logic              m_wreg_nxt, s_wreg_nxt;
  logic [DATA_W-1:0] m_data_nxt, s_data_nxt;

  logic              acc, ret, cap_wreg;
  logic [CNT_W-1:0]  stall_cnt_p1;

  // in_ready depends only on registered state, so out_ready never reaches it.
  assign in_ready  = !s_vld_p1;
  assign out_valid = m_vld_p1;
  assign acc       = in_valid && in_ready;
  assign ret       = m_vld_p1 && out_ready;

  // A write to x0 is turned into a no-write at capture time.
  assign cap_wreg  = ZERO_SUPPRESS ? (in_wreg && (in_rd_addr != '0)) : in_wreg;

  // Next-state of both entries; flush wins and drops any same-cycle accept.
  always_comb begin
    m_vld_nxt  = m_vld_p1;
    m_rd_nxt   = m_rd_p1;
    m_wreg_nxt = m_wreg_p1;
    m_data_nxt = m_data_p1;
    s_vld_nxt  = s_vld_p1;
    s_rd_nxt   = s_rd_p1;
    s_wreg_nxt = s_wreg_p1;
    s_data_nxt = s_data_p1;
    if (flush) begin
      m_vld_nxt = 1'b0;
      s_vld_nxt = 1'b0;
    end else if (!m_vld_p1) begin
      if (acc) begin
        m_vld_nxt  = 1'b1;
        m_rd_nxt   = in_rd_addr;
        m_wreg_nxt = cap_wreg;
        m_data_nxt = in_wdata;
      end
    end else if (ret) begin
      if (s_vld_p1) begin
        m_rd_nxt   = s_rd_p1;
        m_wreg_nxt = s_wreg_p1;
        m_data_nxt = s_data_p1;
        s_vld_nxt  = 1'b0;
      end else if (acc) begin
        m_rd_nxt   = in_rd_addr;
        m_wreg_nxt = cap_wreg;
        m_data_nxt = in_wdata;
      end else begin
        m_vld_nxt = 1'b0;
      end
    end else if (acc) begin
      s_vld_nxt  = 1'b1;
      s_rd_nxt   = in_rd_addr;
      s_wreg_nxt = cap_wreg;
      s_data_nxt = in_wdata;
    end
  end

  // ---- stage boundary: entry registers ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_vld_p1  <= 1'b0;
      m_rd_p1   <= '0;
      m_wreg_p1 <= 1'b0;
      m_data_p1 <= '0;
      s_vld_p1  <= 1'b0;
      s_rd_p1   <= '0;
      s_wreg_p1 <= 1'b0;
      s_data_p1 <= '0;
    end else begin
      m_vld_p1  <= m_vld_nxt;
      m_rd_p1   <= m_rd_nxt;
      m_wreg_p1 <= m_wreg_nxt;
      m_data_p1 <= m_data_nxt;
      s_vld_p1  <= s_vld_nxt;
      s_rd_p1   <= s_rd_nxt;
      s_wreg_p1 <= s_wreg_nxt;
      s_data_p1 <= s_data_nxt;
    end
  end

  assign out_rd_addr = m_rd_p1;
  assign out_wreg    = m_wreg_p1;
  assign out_wdata   = m_data_p1;

  // Forward the youngest writing entry: S is younger than M when both valid.
  always_comb begin
    fwd_valid   = 1'b0;
    fwd_rd_addr = '0;
    fwd_wdata   = '0;
    if (s_vld_p1 && s_wreg_p1) begin
      fwd_valid   = 1'b1;
      fwd_rd_addr = s_rd_p1;
      fwd_wdata   = s_data_p1;
    end else if (m_vld_p1 && m_wreg_p1) begin
      fwd_valid   = 1'b1;
      fwd_rd_addr = m_rd_p1;
      fwd_wdata   = m_data_p1;
    end
  end

  // Stall counter: clear has priority, flush does not touch it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_p1 <= '0;
    end else if (cnt_clr) begin
      stall_cnt_p1 <= '0;
    end else if (m_vld_p1 && !out_ready) begin
      stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end
  end

  assign stall_cnt = stall_cnt_p1;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Bench for mem_wb_skid_stage: directed steps then random traffic, checked
// against a queue-based model of a two-deep FIFO stage.
module tb_mem_wb_skid_stage;
  localparam int DW = 64;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, in_valid, in_wreg, out_ready, cnt_clr;
  logic [AW-1:0] in_rd_addr;
  logic [DW-1:0] in_wdata;

  logic          a_in_ready, a_out_valid, a_out_wreg, a_fwd_valid;
  logic [AW-1:0] a_out_rd_addr, a_fwd_rd_addr;
  logic [DW-1:0] a_out_wdata, a_fwd_wdata;
  logic [3:0]    a_stall_cnt;

  logic          b_in_ready, b_out_valid, b_out_wreg, b_fwd_valid;
  logic [AW-1:0] b_out_rd_addr, b_fwd_rd_addr;
  logic [DW-1:0] b_out_wdata, b_fwd_wdata;
  logic [15:0]   b_stall_cnt;

  mem_wb_skid_stage #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(4), .ZERO_SUPPRESS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_rd_addr(in_rd_addr), .in_wreg(in_wreg), .in_wdata(in_wdata),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_rd_addr(a_out_rd_addr),
    .out_wreg(a_out_wreg), .out_wdata(a_out_wdata), .fwd_valid(a_fwd_valid),
    .fwd_rd_addr(a_fwd_rd_addr), .fwd_wdata(a_fwd_wdata), .cnt_clr(cnt_clr),
    .stall_cnt(a_stall_cnt));

  mem_wb_skid_stage #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(16), .ZERO_SUPPRESS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_rd_addr(in_rd_addr), .in_wreg(in_wreg), .in_wdata(in_wdata),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_rd_addr(b_out_rd_addr),
    .out_wreg(b_out_wreg), .out_wdata(b_out_wdata), .fwd_valid(b_fwd_valid),
    .fwd_rd_addr(b_fwd_rd_addr), .fwd_wdata(b_fwd_wdata), .cnt_clr(cnt_clr),
    .stall_cnt(b_stall_cnt));

  typedef struct packed {
    logic [AW-1:0] rd;
    logic          wreg;
    logic [DW-1:0] data;
  } ent_t;

  ent_t q[$];          // entries held by the stage, oldest first
  int   cnt   = 0;     // unbounded count of stalled cycles
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int            n;
    logic          fv;
    logic [AW-1:0] frd;
    logic [DW-1:0] fd;
    n   = q.size();
    fv  = 1'b0;
    frd = '0;
    fd  = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (q[i].wreg && q[i].rd != '0) begin
        fv  = 1'b1;
        frd = q[i].rd;
        fd  = q[i].data;
        break;
      end
    end
    chk("a_in_ready",  64'(a_in_ready),  64'(n < 2));
    chk("a_out_valid", 64'(a_out_valid), 64'(n > 0));
    chk("b_in_ready",  64'(b_in_ready),  64'(n < 2));
    chk("b_out_valid", 64'(b_out_valid), 64'(n > 0));
    if (n > 0) begin
      chk("a_out_rd_addr", 64'(a_out_rd_addr), 64'(q[0].rd));
      chk("a_out_wdata",   a_out_wdata,        q[0].data);
      chk("a_out_wreg",    64'(a_out_wreg),    64'(q[0].wreg && q[0].rd != '0));
      chk("b_out_rd_addr", 64'(b_out_rd_addr), 64'(q[0].rd));
      chk("b_out_wdata",   b_out_wdata,        q[0].data);
      chk("b_out_wreg",    64'(b_out_wreg),    64'(q[0].wreg));
    end
    chk("a_fwd_valid",   64'(a_fwd_valid),   64'(fv));
    chk("a_fwd_rd_addr", 64'(a_fwd_rd_addr), 64'(frd));
    chk("a_fwd_wdata",   a_fwd_wdata,        fd);
    chk("a_stall_cnt",   64'(a_stall_cnt),   64'(cnt > 15 ? 15 : cnt));
    chk("b_stall_cnt",   64'(b_stall_cnt),   64'(cnt > 65535 ? 65535 : cnt));
  endtask

  // One clock: check at negedge, then advance the model across the rising edge.
  task automatic step();
    int   n;
    bit   acc, ret, f;
    ent_t e;
    @(negedge clk);
    check_all();
    n      = q.size();
    acc    = in_valid && (n < 2);
    ret    = (n > 0) && out_ready;
    f      = flush;
    e.rd   = in_rd_addr;
    e.wreg = in_wreg;
    e.data = in_wdata;
    if (cnt_clr) cnt = 0;
    else if (n > 0 && !out_ready) cnt++;
    @(posedge clk);
    if (f) q.delete();
    else begin
      if (ret) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
  endtask

  task automatic drv(input bit v, input logic [AW-1:0] rd, input bit w,
                     input logic [DW-1:0] d, input bit ordy);
    in_valid   = v;
    in_rd_addr = rd;
    in_wreg    = w;
    in_wdata   = d;
    out_ready  = ordy;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  64'(a_in_ready),    64'(1));
    chk({tag, "_out_valid"}, 64'(a_out_valid),   64'(0));
    chk({tag, "_fwd_valid"}, 64'(a_fwd_valid),   64'(0));
    chk({tag, "_out_rd"},    64'(a_out_rd_addr), 64'(0));
    chk({tag, "_out_wdata"}, a_out_wdata,        64'(0));
    chk({tag, "_out_wreg"},  64'(a_out_wreg),    64'(0));
    chk({tag, "_stall"},     64'(a_stall_cnt),   64'(0));
    chk({tag, "_b_in_rdy"},  64'(b_in_ready),    64'(1));
    chk({tag, "_b_out_vld"}, 64'(b_out_valid),   64'(0));
    chk({tag, "_b_stall"},   64'(b_stall_cnt),   64'(0));
  endtask

  initial begin
    bit will;
    rst = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    drv(0, '0, 0, '0, 0);
    #12;
    check_reset_outputs("reset");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // single transfer rd=3 data=DEAD
    drv(1, 5'd3, 1, 64'hDEAD, 1); step();
    drv(0, '0, 0, '0, 1);         step(); step(); step();

    // back-to-back stream 1..8
    for (int i = 1; i <= 8; i++) begin
      drv(1, AW'(i), 1, 64'(i), 1); step();
    end
    drv(0, '0, 0, '0, 1); step(); step();

    // back-pressure with A, B, C; C waits upstream until accepted
    drv(1, 5'd10, 1, 64'hA, 0); step();
    drv(1, 5'd11, 1, 64'hB, 0); step();
    drv(1, 5'd12, 1, 64'hC, 0); step(); step(); step();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      will = (q.size() < 2);
      step();
      if (will) break;
    end
    drv(0, '0, 0, '0, 1); step(); step(); step();

    // write to x0
    drv(1, 5'd0, 1, 64'h55, 1); step();
    drv(0, '0, 0, '0, 1);       step(); step();

    // flush with both entries full and a new offer
    drv(1, 5'd7, 1, 64'h77, 0); step();
    drv(1, 5'd8, 1, 64'h88, 0); step();
    drv(1, 5'd9, 1, 64'h99, 0); flush = 1'b1; step();
    flush = 1'b0; drv(0, '0, 0, '0, 1); step(); step(); step();

    // counter saturation, clear, then asynchronous reset mid-stall
    drv(1, 5'd4, 1, 64'h44, 0); step();
    drv(0, '0, 0, '0, 0);
    for (int i = 0; i < 20; i++) step();
    cnt_clr = 1'b1; step();
    cnt_clr = 1'b0; step(); step();
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    q.delete(); cnt = 0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drv(($urandom % 4) != 0, AW'($urandom), $urandom % 2,
          {$urandom, $urandom}, ($urandom % 3) != 0);
      flush   = ($urandom % 25) == 0;
      cnt_clr = ($urandom % 40) == 0;
      step();
    end
    drv(0, '0, 0, '0, 1); flush = 1'b0; cnt_clr = 1'b0;
    step(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
